// File: rtl/rgb565_ycbcr422_enc.sv
// RGB565 to YCbCr 4:2:2 byte-stream encoder.
// Takes pixel pairs through a handshake, computes BT.601 studio-range Y0/Y1 and shared Cb/Cr
// over two pipeline states, then emits Cb, Y0, Cr, Y1 on consecutive cycles.
module rgb565_ycbcr422_enc #(
   parameter int Y_MIN = 16,
   parameter int Y_MAX = 235,
   parameter int C_MAX = 240
) (
   input  logic        clk_llc,
   input  logic        reset,
   input  logic        pix_valid,
   input  logic [15:0] pix_rgb,
   input  logic        pix_last,
   output logic        pix_ready,
   output logic [7:0]  vpo_out,
   output logic        vpo_valid,
   output logic        vpo_first
);

   localparam logic signed [17:0] YMinS = 18'(Y_MIN);
   localparam logic signed [17:0] YMaxS = 18'(Y_MAX);
   localparam logic signed [17:0] CMaxS = 18'(C_MAX);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StPix1 = 3'd1,
      StMul  = 3'd2,
      StSum  = 3'd3,
      StEmit = 3'd4
   } state_t;

   state_t      state_q;
   logic [1:0]  phase_q;
   logic [15:0] p0_q, p1_q;

   // Luma products per pixel
   logic [15:0] y_r0_q, y_g0_q, y_b0_q;
   logic [15:0] y_r1_q, y_g1_q, y_b1_q;
   // Chroma product magnitudes; signs are applied in the sum
   logic [15:0] cb_r_q, cb_g_q, cb_b_q;
   logic [15:0] cr_r_q, cr_g_q, cr_b_q;

   // Results held for the later emit phases (Cb goes straight to the output register)
   logic [7:0]  y0_q, y1_q, cr_q;

   logic [7:0]  vpo_out_q;
   logic        vpo_valid_q;
   logic        vpo_first_q;

   // Expanded channels and pair averages
   logic [7:0]  r8_0, g8_0, b8_0;
   logic [7:0]  r8_1, g8_1, b8_1;
   logic [7:0]  r_avg, g_avg, b_avg;

   logic [17:0]        y0_sum, y1_sum;
   logic signed [17:0] y0_val, y1_val;
   logic signed [17:0] cb_sum, cr_sum;
   logic signed [17:0] cb_val, cr_val;

   function automatic logic [7:0] clamp8(input logic signed [17:0] v,
                                         input logic signed [17:0] lo,
                                         input logic signed [17:0] hi);
      logic [7:0] res;
      if (v < lo) begin
         res = lo[7:0];
      end else if (v > hi) begin
         res = hi[7:0];
      end else begin
         res = v[7:0];
      end
      return res;
   endfunction

   // Channel expansion, averaging and the offset/rounded sums, all from registered state
   always_comb begin
      r8_0 = {p0_q[15:11], p0_q[15:13]};
      g8_0 = {p0_q[10:5],  p0_q[10:9]};
      b8_0 = {p0_q[4:0],   p0_q[4:2]};
      r8_1 = {p1_q[15:11], p1_q[15:13]};
      g8_1 = {p1_q[10:5],  p1_q[10:9]};
      b8_1 = {p1_q[4:0],   p1_q[4:2]};

      r_avg = 8'((9'(r8_0) + 9'(r8_1) + 9'd1) >> 1);
      g_avg = 8'((9'(g8_0) + 9'(g8_1) + 9'd1) >> 1);
      b_avg = 8'((9'(b8_0) + 9'(b8_1) + 9'd1) >> 1);

      y0_sum = 18'(y_r0_q) + 18'(y_g0_q) + 18'(y_b0_q) + 18'd128;
      y1_sum = 18'(y_r1_q) + 18'(y_g1_q) + 18'(y_b1_q) + 18'd128;
      y0_val = $signed(y0_sum >> 8) + 18'sd16;
      y1_val = $signed(y1_sum >> 8) + 18'sd16;

      cb_sum = $signed(18'(cb_b_q)) - $signed(18'(cb_r_q)) - $signed(18'(cb_g_q)) + 18'sd128;
      cr_sum = $signed(18'(cr_r_q)) - $signed(18'(cr_g_q)) - $signed(18'(cr_b_q)) + 18'sd128;
      // Arithmetic shift floors negative sums toward minus infinity
      cb_val = (cb_sum >>> 8) + 18'sd128;
      cr_val = (cr_sum >>> 8) + 18'sd128;
   end

   // Control FSM with datapath registers and registered byte-stream outputs
   always_ff @(posedge clk_llc) begin
      if (reset) begin
         state_q     <= StIdle;
         phase_q     <= 2'd0;
         p0_q        <= '0;
         p1_q        <= '0;
         y_r0_q      <= '0;
         y_g0_q      <= '0;
         y_b0_q      <= '0;
         y_r1_q      <= '0;
         y_g1_q      <= '0;
         y_b1_q      <= '0;
         cb_r_q      <= '0;
         cb_g_q      <= '0;
         cb_b_q      <= '0;
         cr_r_q      <= '0;
         cr_g_q      <= '0;
         cr_b_q      <= '0;
         y0_q        <= '0;
         y1_q        <= '0;
         cr_q        <= '0;
         vpo_out_q   <= '0;
         vpo_valid_q <= 1'b0;
         vpo_first_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pix_valid) begin
                  p0_q <= pix_rgb;
                  if (pix_last) begin
                     // Lone pixel at end of line: pair it with itself
                     p1_q    <= pix_rgb;
                     state_q <= StMul;
                  end else begin
                     state_q <= StPix1;
                  end
               end
            end
            StPix1: begin
               if (pix_valid) begin
                  p1_q    <= pix_rgb;
                  state_q <= StMul;
               end
            end
            StMul: begin
               y_r0_q  <= 16'(r8_0) * 16'd66;
               y_g0_q  <= 16'(g8_0) * 16'd129;
               y_b0_q  <= 16'(b8_0) * 16'd25;
               y_r1_q  <= 16'(r8_1) * 16'd66;
               y_g1_q  <= 16'(g8_1) * 16'd129;
               y_b1_q  <= 16'(b8_1) * 16'd25;
               cb_r_q  <= 16'(r_avg) * 16'd38;
               cb_g_q  <= 16'(g_avg) * 16'd74;
               cb_b_q  <= 16'(b_avg) * 16'd112;
               cr_r_q  <= 16'(r_avg) * 16'd112;
               cr_g_q  <= 16'(g_avg) * 16'd94;
               cr_b_q  <= 16'(b_avg) * 16'd18;
               state_q <= StSum;
            end
            StSum: begin
               y0_q        <= clamp8(y0_val, YMinS, YMaxS);
               y1_q        <= clamp8(y1_val, YMinS, YMaxS);
               cr_q        <= clamp8(cr_val, YMinS, CMaxS);
               // Phase 0 byte is loaded here so it is visible on the first EMIT cycle
               vpo_out_q   <= clamp8(cb_val, YMinS, CMaxS);
               vpo_valid_q <= 1'b1;
               vpo_first_q <= 1'b1;
               phase_q     <= 2'd0;
               state_q     <= StEmit;
            end
            StEmit: begin
               // Each edge loads the byte for the next phase
               unique case (phase_q)
                  2'd0: begin
                     vpo_out_q   <= y0_q;
                     vpo_first_q <= 1'b0;
                     phase_q     <= 2'd1;
                  end
                  2'd1: begin
                     vpo_out_q <= cr_q;
                     phase_q   <= 2'd2;
                  end
                  2'd2: begin
                     vpo_out_q <= y1_q;
                     phase_q   <= 2'd3;
                  end
                  default: begin
                     vpo_out_q   <= '0;
                     vpo_valid_q <= 1'b0;
                     vpo_first_q <= 1'b0;
                     phase_q     <= 2'd0;
                     state_q     <= StIdle;
                  end
               endcase
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign pix_ready = (state_q == StIdle) || (state_q == StPix1);
   assign vpo_out   = vpo_out_q;
   assign vpo_valid = vpo_valid_q;
   assign vpo_first = vpo_first_q;

endmodule

// File: tb/tb_rgb565_ycbcr422_enc.sv
// Scoreboard bench for rgb565_ycbcr422_enc: the driver pushes expected bytes and cycles,
// a monitor pops and compares whenever a byte is presented.
module tb_rgb565_ycbcr422_enc;

   logic        clk_llc = 1'b0;
   logic        reset = 1'b1;
   logic        pix_valid = 1'b0;
   logic [15:0] pix_rgb = 16'h0;
   logic        pix_last = 1'b0;
   logic        pix_ready;
   logic [7:0]  vpo_out;
   logic        vpo_valid;
   logic        vpo_first;

   rgb565_ycbcr422_enc dut (
      .clk_llc   (clk_llc),
      .reset     (reset),
      .pix_valid (pix_valid),
      .pix_rgb   (pix_rgb),
      .pix_last  (pix_last),
      .pix_ready (pix_ready),
      .vpo_out   (vpo_out),
      .vpo_valid (vpo_valid),
      .vpo_first (vpo_first)
   );

   always #5 clk_llc = ~clk_llc;

   int cyc = 0;
   always @(posedge clk_llc) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] b;
      bit         first;
      int         cyc;
   } exp_t;
   exp_t exp_q[$];

   // Transaction-level model state
   int          ready_at = 0;
   bit          have_p0 = 0;
   logic [15:0] p0_m = 16'h0;
   int          last_cb_cyc = 0;
   bit          use_ovr = 0;
   logic [31:0] ovr = 32'h0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int fdiv256(input int x);
      if (x >= 0) return x / 256;
      return -((-x + 255) / 256);
   endfunction

   function automatic int clampi(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   // Returns {Cb, Y0, Cr, Y1} for a pixel pair
   function automatic logic [31:0] ref_model(input logic [15:0] a, input logic [15:0] b);
      int ra, ga, ba, rb, gb, bb;
      int r8a, g8a, b8a, r8b, g8b, b8b;
      int ya, yb, rav, gav, bav, cb, cr;
      ra = int'(a[15:11]); ga = int'(a[10:5]); ba = int'(a[4:0]);
      rb = int'(b[15:11]); gb = int'(b[10:5]); bb = int'(b[4:0]);
      r8a = ra * 8 + ra / 4; g8a = ga * 4 + ga / 16; b8a = ba * 8 + ba / 4;
      r8b = rb * 8 + rb / 4; g8b = gb * 4 + gb / 16; b8b = bb * 8 + bb / 4;
      ya = clampi(16 + (66 * r8a + 129 * g8a + 25 * b8a + 128) / 256, 16, 235);
      yb = clampi(16 + (66 * r8b + 129 * g8b + 25 * b8b + 128) / 256, 16, 235);
      rav = (r8a + r8b + 1) / 2;
      gav = (g8a + g8b + 1) / 2;
      bav = (b8a + b8b + 1) / 2;
      cb = clampi(128 + fdiv256(-38 * rav - 74 * gav + 112 * bav + 128), 16, 240);
      cr = clampi(128 + fdiv256(112 * rav - 94 * gav - 18 * bav + 128), 16, 240);
      return {8'(cb), 8'(ya), 8'(cr), 8'(yb)};
   endfunction

   // One input cycle: drive at the falling edge, check readiness, update the model
   task automatic step(input bit v, input logic [15:0] d, input bit l, output bit acc);
      bit          exp_rdy;
      logic [15:0] a;
      logic [31:0] res;
      exp_t        e;
      @(negedge clk_llc);
      pix_valid = v;
      pix_rgb   = d;
      pix_last  = l;
      #1;
      exp_rdy = (cyc >= ready_at);
      chk("pix_ready", int'(pix_ready), int'(exp_rdy));
      acc = v && exp_rdy;
      if (acc) begin
         if (!have_p0 && !l) begin
            have_p0 = 1;
            p0_m    = d;
         end else begin
            a   = have_p0 ? p0_m : d;
            res = use_ovr ? ovr : ref_model(a, d);
            for (int k = 0; k < 4; k++) begin
               e.b     = res[31-8*k -: 8];
               e.first = (k == 0);
               e.cyc   = cyc + 3 + k;
               exp_q.push_back(e);
            end
            last_cb_cyc = cyc + 3;
            ready_at    = cyc + 7;
            have_p0     = 0;
         end
      end
   endtask

   task automatic send_pixel(input logic [15:0] d, input bit l);
      bit acc = 0;
      int n = 0;
      while (!acc && n < 60) begin
         step(1'b1, d, l, acc);
         n++;
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: pixel %0h never accepted", d);
      end
   endtask

   task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input bit single);
      send_pixel(a, single);
      if (!single) send_pixel(b, 1'b0);
   endtask

   // Monitor: compares every presented byte against the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_llc);
         #2;
         if (vpo_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_byte: got %0h expected no output (cycle %0d)", vpo_out, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("vpo_out", int'(vpo_out), int'(e.b));
               chk("vpo_first", int'(vpo_first), int'(e.first));
               chk("byte_cycle", cyc, e.cyc);
            end
         end else begin
            chk("idle_out_zero", int'(vpo_out), 0);
            chk("idle_first_zero", int'(vpo_first), 0);
         end
      end
   end

   initial begin
      bit acc;
      int n;
      repeat (3) @(negedge clk_llc);
      reset = 1'b0;
      @(negedge clk_llc);
      #1;
      chk("rst_ready", int'(pix_ready), 1);
      chk("rst_valid", int'(vpo_valid), 0);
      chk("rst_out", int'(vpo_out), 0);

      // Directed pairs with known byte streams
      use_ovr = 1;
      ovr = 32'h80EB80EB; send_pair(16'hFFFF, 16'hFFFF, 1'b0);
      ovr = 32'h80108010; send_pair(16'h0000, 16'h0000, 1'b0);
      ovr = 32'h5A52F052; send_pair(16'hF800, 16'hF800, 1'b0);
      ovr = 32'h5A52F052; send_pair(16'hF800, 16'h0000, 1'b1);
      use_ovr = 0;

      // Abort a pair with reset on the EMIT phase-1 edge
      send_pair(16'($urandom), 16'($urandom), 1'b0);
      n = 0;
      while (cyc != last_cb_cyc + 1 && n < 30) begin
         step(1'b0, 16'h0, 1'b0, acc);
         n++;
      end
      chk("abort_reach_phase1", cyc, last_cb_cyc + 1);
      reset = 1'b1;
      chk("abort_pending", exp_q.size(), 2);
      exp_q.delete();
      @(negedge clk_llc);
      #1;
      chk("abort_valid", int'(vpo_valid), 0);
      reset = 1'b0;
      ready_at = 0;
      have_p0 = 0;
      @(negedge clk_llc);
      #1;
      chk("post_reset_ready", int'(pix_ready), 1);

      // Random traffic
      repeat (300) step(($urandom % 3) != 0, 16'($urandom), ($urandom % 4) == 0, acc);
      // Valid held high continuously
      repeat (200) step(1'b1, 16'($urandom), ($urandom % 5) == 0, acc);

      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         step(1'b0, 16'h0, 1'b0, acc);
         n++;
      end
      chk("drain_empty", exp_q.size(), 0);
      repeat (4) step(1'b0, 16'h0, 1'b0, acc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
